slider_movegen: RTL and testbench
=================================

Name: slider_movegen

Overview:
- Generalised sliding-piece move generator; successor to the single-piece bishop/rook generators.
- CPU selects any subset of the 8 ray directions and a maximum ray length, so one block covers bishop, rook, queen and king-step moves.
- Reads a 64-square board from SDRAM through an Avalon-MM master and writes one full successor board per legal move to a contiguous output area.
- Sits on the HPS/Nios bus as an Avalon-MM slave; the result count is readable at slave address 0.

Parameters:
- ADDR_STEP, 4, byte stride between consecutive squares (one square per 32-bit word).
- SQ_W, 8, significant signed bits per square; sign gives colour (>0 white, <0 black, 0 empty).
- MAX_MOVES, 27, saturation limit for the generated-board count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- slave_waitrequest  out  1  stall to CPU
- slave_address  in  4  register index
- slave_read  in  1  CPU read strobe
- slave_readdata  out  32  read data; move count zero-extended
- slave_write  in  1  CPU write strobe
- slave_writedata  in  32  write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  SDRAM byte address
- master_read  out  1  SDRAM read strobe
- master_readdata  in  32  SDRAM read data
- master_readdatavalid  in  1  read data valid
- master_write  out  1  SDRAM write strobe
- master_writedata  out  32  SDRAM write data, sign-extended square value

Behaviour:
- Reset values: all master strobes 0, slave_waitrequest 0, count 0, FSM in IDLE. Reset mid-operation aborts on the same edge; no further bus strobes.
- Registers, written in IDLE with zero waitrequest:
  - 1 = src, 2 = dest, 3 = x (bits 2:0), 4 = y (bits 2:0).
  - 5 = dir_mask[7:0], bit order N, NE, E, SE, S, SW, W, NW; N is +y, E is +x.
  - 6 = range (1..7; 0 is treated as 7).
  - Write to 0 = start.
- Square index is y*8+x; its address is base + index*ADDR_STEP.
- Board k (0-based) is written at dest + k*64*ADDR_STEP.
- FSM states: IDLE → LOAD_REQ → LOAD_WAIT (×64) → DIR_SEL → STEP → EVAL → WRITE_REQ (×64) → back to STEP or DIR_SEL → DONE → IDLE.
- LOAD:
  - Exactly one outstanding read.
  - master_read and master_address are held until master_waitrequest is low, then the read drops.
  - Data is captured only on master_readdatavalid into a 64×SQ_W board buffer.
- Piece and colour are taken from buffer[y*8+x]. If that square is empty, go straight to DONE with count 0 and issue no writes.
- DIR_SEL: scan the 8 mask bits in ascending order; skip cleared bits; reset ray position to (x,y) and step counter to 0. No bits left → DONE.
- STEP: position += direction delta using signed 4-bit arithmetic; step counter +1.
- EVAL, in priority order:
  - Off-board (coordinate <0 or >7), step counter > range, or target has the mover's colour → end ray (DIR_SEL).
  - Otherwise emit a board. If the target was an enemy piece, the ray ends after this board.
- WRITE_REQ:
  - Write 64 words in index order: origin square = 0, target = piece, all others copied from the buffer.
  - master_write, master_address and master_writedata are held stable while master_waitrequest is high; advance only on a cycle where it is low.
- Count increments once per completed board. At MAX_MOVES it saturates: remaining rays are abandoned and the FSM goes to DONE.
- Start or argument writes while busy: slave_waitrequest is held high until DONE.
- Slave read of address 0 while busy stalls; in IDLE it returns the last count.
- Reads of any other address return 0 with no stall.
- DONE lasts 1 cycle, then returns to IDLE.

Decomposition:
- Package movegen_pkg holds:
  - colour constants WHITE=1, BLACK=-1, EMPTY=0;
  - the direction enum and the dx/dy lookup function;
  - register index localparams;
  - the colour_of(square) function.
- One sub-module, board_buf: 64×SQ_W register file with one synchronous write port (load path) and two combinational read ports (EVAL target lookup, WRITE_REQ copy).

Test Plan:
- White bishop (3) at d4 (x=3,y=3), empty board otherwise, mask 0xAA, range 7 → 13 boards; board 0 has a 3 at index 36 and a 0 at index 27; read addr 0 = 13.
- White rook at a1, white pawn at a2, black pawn at c1, mask 0x55, range 7 → 2 boards (b1, then the c1 capture); the ray stops after the capture.
- Queen at e4, mask 0xFF, range 1, empty board → 8 boards in N, NE, E, SE, S, SW, W, NW order; range 0 on the same setup → 27 boards.
- Piece at h8, mask 0x02 (NE only) → count 0 and no master_write ever asserted. Empty origin square → count 0 and no writes.
- master_waitrequest asserted randomly 50% on both reads and writes → identical output and count to the no-stall run; no strobe or address change while stalled.
- Assert rst_n low mid-WRITE_REQ → strobes low next cycle; a fresh start afterwards produces correct results.

Source files
------------

// File: rtl/movegen_pkg.sv
// Shared constants, types and helpers for the sliding-piece move generator.
package movegen_pkg;

    localparam int unsigned ADDR_STEP = 4;
    localparam int unsigned SQ_W      = 8;
    localparam int unsigned MAX_MOVES = 27;
    localparam int unsigned CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MOVES - 1);

    localparam logic signed [1:0] WHITE = 2'sd1;
    localparam logic signed [1:0] BLACK = -2'sd1;
    localparam logic signed [1:0] EMPTY = 2'sd0;

    localparam logic [3:0] RegStart = 4'd0;
    localparam logic [3:0] RegSrc   = 4'd1;
    localparam logic [3:0] RegDest  = 4'd2;
    localparam logic [3:0] RegX     = 4'd3;
    localparam logic [3:0] RegY     = 4'd4;
    localparam logic [3:0] RegMask  = 4'd5;
    localparam logic [3:0] RegRange = 4'd6;

    typedef enum logic [2:0] {
        DirN, DirNe, DirE, DirSe, DirS, DirSw, DirW, DirNw
    } dir_e;

    typedef enum logic [2:0] {
        StIdle, StLoadReq, StLoadWait, StDirSel, StStep, StEval, StWriteReq, StDone
    } state_e;

    typedef struct packed {
        logic signed [3:0] dx;
        logic signed [3:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input dir_e d);
        delta_t r;
        case (d)
            DirN:    begin r.dx =  4'sd0; r.dy =  4'sd1; end
            DirNe:   begin r.dx =  4'sd1; r.dy =  4'sd1; end
            DirE:    begin r.dx =  4'sd1; r.dy =  4'sd0; end
            DirSe:   begin r.dx =  4'sd1; r.dy = -4'sd1; end
            DirS:    begin r.dx =  4'sd0; r.dy = -4'sd1; end
            DirSw:   begin r.dx = -4'sd1; r.dy = -4'sd1; end
            DirW:    begin r.dx = -4'sd1; r.dy =  4'sd0; end
            default: begin r.dx = -4'sd1; r.dy =  4'sd1; end
        endcase
        return r;
    endfunction

    function automatic logic signed [1:0] colour_of(input logic [SQ_W-1:0] sq);
        if (sq == '0) begin
            return EMPTY;
        end else if (sq[SQ_W-1]) begin
            return BLACK;
        end
        return WHITE;
    endfunction

endpackage

// File: rtl/board_buf.sv
// 64-square board buffer: one synchronous write port fed by the load path and
// two combinational read ports (ray target lookup and successor-board copy).
module board_buf
    import movegen_pkg::*;
(
    input  logic            clk,
    input  logic            we_i,
    input  logic [5:0]      waddr_i,
    input  logic [SQ_W-1:0] wdata_i,
    input  logic [5:0]      raddr_a_i,
    output logic [SQ_W-1:0] rdata_a_o,
    input  logic [5:0]      raddr_b_i,
    output logic [SQ_W-1:0] rdata_b_o
);

    logic [SQ_W-1:0] mem_q [64];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/slider_movegen.sv
// Sliding-piece move generator: loads a board over Avalon-MM, walks the selected
// rays and writes one full successor board per legal move.
module slider_movegen
    import movegen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    state_e                state_q, state_d;
    logic [31:0]           src_q, src_d;
    logic [31:0]           dest_q, dest_d;
    logic [2:0]            x_q, x_d;
    logic [2:0]            y_q, y_d;
    logic [7:0]            mask_q, mask_d;
    logic [2:0]            range_q, range_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [5:0]            idx_q, idx_d;
    dir_e                  dir_q, dir_d;
    logic [3:0]            dir_next_q, dir_next_d;
    logic signed [3:0]     px_q, px_d;
    logic signed [3:0]     py_q, py_d;
    logic [3:0]            step_q, step_d;
    logic [SQ_W-1:0]       piece_q, piece_d;
    logic                  last_q, last_d;

    logic [5:0]            origin_idx;
    logic [5:0]            tgt_idx;
    logic [3:0]            range_eff;
    logic [SQ_W-1:0]       tgt_sq;
    logic [SQ_W-1:0]       copy_sq;
    logic [SQ_W-1:0]       out_sq;
    logic                  off_board;
    logic                  friendly;
    logic                  ray_end;
    logic                  buf_we;
    delta_t                delta;
    logic                  unused_rdata;

    assign unused_rdata = ^master_readdata[31:SQ_W];

    assign origin_idx = {y_q, x_q};
    assign tgt_idx    = {py_q[2:0], px_q[2:0]};
    assign range_eff  = (range_q == 3'd0) ? 4'd7 : {1'b0, range_q};
    // Coordinates live in -1..8; 8 wraps to -8, so the sign bit alone flags off-board.
    assign off_board  = px_q[3] | py_q[3];
    assign friendly   = colour_of(tgt_sq) == colour_of(piece_q);
    assign ray_end    = off_board || (step_q > range_eff) || friendly;
    assign buf_we     = (state_q == StLoadWait) && master_readdatavalid;
    assign delta      = dir_delta(dir_q);

    board_buf u_board_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .waddr_i   (idx_q),
        .wdata_i   (master_readdata[SQ_W-1:0]),
        .raddr_a_i (tgt_idx),
        .rdata_a_o (tgt_sq),
        .raddr_b_i (idx_q),
        .rdata_b_o (copy_sq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dest_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            mask_q     <= '0;
            range_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            dir_q      <= DirN;
            dir_next_q <= '0;
            px_q       <= '0;
            py_q       <= '0;
            step_q     <= '0;
            piece_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mask_q     <= mask_d;
            range_q    <= range_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            dir_next_q <= dir_next_d;
            px_q       <= px_d;
            py_q       <= py_d;
            step_q     <= step_d;
            piece_q    <= piece_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (slave_write && slave_address == RegStart) begin
                    state_d = StLoadReq;
                end
            end
            StLoadReq: begin
                if (!master_waitrequest) begin
                    state_d = StLoadWait;
                end
            end
            StLoadWait: begin
                if (master_readdatavalid) begin
                    state_d = (idx_q == 6'd63) ? StDirSel : StLoadReq;
                end
            end
            StDirSel: begin
                if (piece_q == '0 || dir_next_q[3]) begin
                    state_d = StDone;
                end else if (mask_q[dir_next_q[2:0]]) begin
                    state_d = StStep;
                end
            end
            StStep: state_d = StEval;
            StEval: state_d = ray_end ? StDirSel : StWriteReq;
            StWriteReq: begin
                if (!master_waitrequest && idx_q == 6'd63) begin
                    if (count_q == CNT_LAST) begin
                        state_d = StDone;
                    end else if (last_q) begin
                        state_d = StDirSel;
                    end else begin
                        state_d = StStep;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        src_d      = src_q;
        dest_d     = dest_q;
        x_d        = x_q;
        y_d        = y_q;
        mask_d     = mask_q;
        range_d    = range_q;
        count_d    = count_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        dir_next_d = dir_next_q;
        px_d       = px_q;
        py_d       = py_q;
        step_d     = step_q;
        piece_d    = piece_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (slave_write) begin
                    case (slave_address)
                        RegStart: begin
                            idx_d      = '0;
                            count_d    = '0;
                            piece_d    = '0;
                            dir_next_d = '0;
                        end
                        RegSrc:   src_d   = slave_writedata;
                        RegDest:  dest_d  = slave_writedata;
                        RegX:     x_d     = slave_writedata[2:0];
                        RegY:     y_d     = slave_writedata[2:0];
                        RegMask:  mask_d  = slave_writedata[7:0];
                        RegRange: range_d = slave_writedata[2:0];
                        default: ;
                    endcase
                end
            end
            StLoadWait: begin
                if (master_readdatavalid) begin
                    if (idx_q == origin_idx) begin
                        piece_d = master_readdata[SQ_W-1:0];
                    end
                    idx_d = idx_q + 6'd1;
                end
            end
            StDirSel: begin
                if (piece_q != '0 && !dir_next_q[3]) begin
                    dir_next_d = dir_next_q + 4'd1;
                    if (mask_q[dir_next_q[2:0]]) begin
                        dir_d  = dir_e'(dir_next_q[2:0]);
                        px_d   = {1'b0, x_q};
                        py_d   = {1'b0, y_q};
                        step_d = '0;
                    end
                end
            end
            StStep: begin
                px_d   = px_q + delta.dx;
                py_d   = py_q + delta.dy;
                step_d = step_q + 4'd1;
            end
            StEval: begin
                if (!ray_end) begin
                    last_d = colour_of(tgt_sq) != EMPTY;
                    idx_d  = '0;
                end
            end
            StWriteReq: begin
                if (!master_waitrequest) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        if (idx_q == origin_idx) begin
            out_sq = '0;
        end else if (idx_q == tgt_idx) begin
            out_sq = piece_q;
        end else begin
            out_sq = copy_sq;
        end
        if (state_q == StLoadReq) begin
            master_read    = 1'b1;
            master_address = src_q + 32'(idx_q) * ADDR_STEP;
        end else if (state_q == StWriteReq) begin
            master_write     = 1'b1;
            master_address   = dest_q + 32'(count_q) * (64 * ADDR_STEP)
                               + 32'(idx_q) * ADDR_STEP;
            master_writedata = {{(32 - SQ_W){out_sq[SQ_W-1]}}, out_sq};
        end
        slave_waitrequest = (state_q != StIdle) &&
                            (slave_write || (slave_read && slave_address == RegStart));
        slave_readdata    = (slave_address == RegStart) ? 32'(count_q) : '0;
    end

endmodule

// File: tb/tb_slider_movegen.sv
// Randomised bench for slider_movegen: an SDRAM model plus a ray-walking
// reference that predicts every successor-board write and the final count.
module tb_slider_movegen;

    localparam logic [31:0] SRC  = 32'h0000_0100;
    localparam logic [31:0] DEST = 32'h0000_1000;
    localparam int          LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    slider_movegen dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [4096];
    int          brd [64];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_n;
    bit          stall_en = 1'b0;
    bit          chk_en = 1'b0;
    int          n_wstrobe = 0;
    int          n_wacc = 0;
    int          dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int          dys [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: walk each selected ray with plain integer geometry.
    task automatic model(input int x, input int y, input logic [7:0] mask, input int rng);
        int piece, nx, ny, t, o, ti, r;
        exp_addr.delete();
        exp_data.delete();
        exp_n = 0;
        o = y * 8 + x;
        piece = brd[o];
        r = (rng == 0) ? 7 : rng;
        if (piece != 0) begin
            for (int d = 0; d < 8; d++) begin
                if (mask[d] && exp_n < 27) begin
                    for (int s = 1; s <= r; s++) begin
                        nx = x + dxs[d] * s;
                        ny = y + dys[d] * s;
                        if (nx < 0 || nx > 7 || ny < 0 || ny > 7) break;
                        ti = ny * 8 + nx;
                        t = brd[ti];
                        if (t != 0 && ((t > 0) == (piece > 0))) break;
                        for (int i = 0; i < 64; i++) begin
                            exp_addr.push_back(DEST + 32'((exp_n * 64 + i) * 4));
                            exp_data.push_back(32'((i == o) ? 0 : (i == ti) ? piece : brd[i]));
                        end
                        exp_n++;
                        if (exp_n == 27 || t != 0) break;
                    end
                end
            end
        end
    endtask

    // SDRAM model: random stalls, variable read latency, write scoreboard.
    logic        rd_pend = 1'b0;
    int          rd_lat = 0;
    logic [31:0] rd_word = '0;
    logic        prev_stall = 1'b0;
    logic [1:0]  prev_strb = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        int w;
        master_readdatavalid = 1'b0;
        if (!rst_n) begin
            rd_pend = 1'b0;
        end else if (rd_pend) begin
            if (rd_lat == 0) begin
                master_readdatavalid = 1'b1;
                master_readdata = rd_word;
                rd_pend = 1'b0;
            end else begin
                rd_lat--;
            end
        end
        master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rst_n && prev_stall) begin
            chk("stall_hold_strobe", 32'({master_read, master_write}), 32'(prev_strb));
            chk("stall_hold_addr", master_address, prev_addr);
            if (prev_strb[0]) chk("stall_hold_data", master_writedata, prev_data);
        end
        prev_stall = rst_n && master_waitrequest && (master_read || master_write);
        prev_strb  = {master_read, master_write};
        prev_addr  = master_address;
        prev_data  = master_writedata;
        w = int'(master_address[13:2]);
        if (master_write) n_wstrobe++;
        if (rst_n && master_read && !master_waitrequest) begin
            rd_word = mem[w];
            rd_pend = 1'b1;
            rd_lat  = $urandom_range(0, 2);
        end
        if (rst_n && master_write && !master_waitrequest) begin
            mem[w] = master_writedata;
            n_wacc++;
            if (chk_en) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual_addr=%0h required=none", master_address);
                end else begin
                    chk("wr_addr", master_address, exp_addr.pop_front());
                    chk("wr_data", master_writedata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic slv_write(input logic [3:0] a, input logic [31:0] d, output int st);
        logic ws = 1'b1;
        st = 0;
        @(negedge clk);
        slave_address = a;
        slave_writedata = d;
        slave_write = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            #1 ws = slave_waitrequest;
            @(posedge clk);
            if (!ws) break;
            st++;
        end
        #1 slave_write = 1'b0;
        if (ws) begin
            checks++;
            failures++;
            $display("FAIL slave_write_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic slv_read(input logic [3:0] a, output logic [31:0] d, output int st);
        logic ws = 1'b1;
        st = 0;
        d = '0;
        @(negedge clk);
        slave_address = a;
        slave_read = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            #1 ws = slave_waitrequest;
            d = slave_readdata;
            @(posedge clk);
            if (!ws) break;
            st++;
        end
        #1 slave_read = 1'b0;
        if (ws) begin
            checks++;
            failures++;
            $display("FAIL slave_read_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic load_board();
        for (int i = 0; i < 64; i++) mem[SRC[13:2] + i] = 32'(brd[i]);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) brd[i] = 0;
    endtask

    task automatic configure(input int x, input int y, input logic [7:0] mask, input int rng);
        int st;
        slv_write(4'd1, SRC, st);
        slv_write(4'd2, DEST, st);
        slv_write(4'd3, 32'(x), st);
        slv_write(4'd4, 32'(y), st);
        slv_write(4'd5, {24'd0, mask}, st);
        slv_write(4'd6, 32'(rng), st);
    endtask

    task automatic run_case(input int x, input int y, input logic [7:0] mask, input int rng);
        logic [31:0] d;
        int st;
        model(x, y, mask, rng);
        load_board();
        chk_en = 1'b1;
        n_wstrobe = 0;
        n_wacc = 0;
        configure(x, y, mask, rng);
        slv_write(4'd0, 32'd0, st);
        slv_read(4'd5, d, st);
        chk("busy_other_read", d, 32'd0);
        chk("busy_other_stall", 32'(st), 32'd0);
        slv_write(4'd5, {24'd0, mask}, st);
        chk("busy_write_stalls", 32'(st > 0), 32'd1);
        slv_read(4'd0, d, st);
        chk("count", d, 32'(exp_n));
        chk("writes_left", 32'(exp_addr.size()), 32'd0);
        chk_en = 1'b0;
    endtask

    function automatic int rnd_piece();
        int v = int'($urandom_range(1, 6));
        return ($urandom_range(0, 1) == 1) ? v : -v;
    endfunction

    initial begin
        logic [31:0] d;
        int st, rx, ry;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_slave_wait", 32'(slave_waitrequest), 32'd0);
        chk("rst_master_read", 32'(master_read), 32'd0);
        chk("rst_master_write", 32'(master_write), 32'd0);
        rst_n = 1'b1;
        slv_read(4'd0, d, st);
        chk("rst_count", d, 32'd0);
        slv_read(4'd3, d, st);
        chk("idle_other_read", d, 32'd0);

        // White bishop on d4, diagonals only.
        clear_board();
        brd[27] = 3;
        run_case(3, 3, 8'hAA, 7);
        chk("bishop_model_n", 32'(exp_n), 32'd13);
        chk("bishop_b0_tgt", mem[DEST[13:2] + 36], 32'd3);
        chk("bishop_b0_org", mem[DEST[13:2] + 27], 32'd0);

        // Rook on a1 blocked north by own pawn, captures on c1.
        clear_board();
        brd[0] = 5;
        brd[8] = 1;
        brd[2] = -1;
        run_case(0, 0, 8'h55, 7);
        chk("rook_model_n", 32'(exp_n), 32'd2);
        chk("rook_b1_capture", mem[DEST[13:2] + 64 + 2], 32'd5);
        chk("rook_b1_org", mem[DEST[13:2] + 64], 32'd0);
        chk("rook_b1_pawn", mem[DEST[13:2] + 64 + 8], 32'd1);

        // Queen on e4: king steps, then full range up to saturation.
        clear_board();
        brd[28] = 9;
        run_case(4, 3, 8'hFF, 1);
        chk("queen1_model_n", 32'(exp_n), 32'd8);
        chk("queen1_b0_n", mem[DEST[13:2] + 36], 32'd9);
        chk("queen1_b2_e", mem[DEST[13:2] + 2 * 64 + 29], 32'd9);
        chk("queen1_b7_nw", mem[DEST[13:2] + 7 * 64 + 35], 32'd9);
        run_case(4, 3, 8'hFF, 0);
        chk("queen7_model_n", 32'(exp_n), 32'd27);
        chk("queen7_b26_org", mem[DEST[13:2] + 26 * 64 + 28], 32'd0);

        // Corner piece with only an off-board ray, and an empty origin.
        clear_board();
        brd[63] = 3;
        run_case(7, 7, 8'h02, 7);
        chk("h8_no_strobe", 32'(n_wstrobe), 32'd0);
        clear_board();
        brd[10] = -4;
        run_case(2, 5, 8'hFF, 0);
        chk("empty_no_strobe", 32'(n_wstrobe), 32'd0);

        // Same setups under random bus stalls.
        stall_en = 1'b1;
        clear_board();
        brd[27] = 3;
        run_case(3, 3, 8'hAA, 7);
        clear_board();
        brd[28] = 9;
        run_case(4, 3, 8'hFF, 0);

        // Reset in the middle of writing a successor board.
        load_board();
        chk_en = 1'b0;
        n_wacc = 0;
        configure(4, 3, 8'hFF, 0);
        slv_write(4'd0, 32'd0, st);
        for (int n = 0; n < LIMIT && n_wacc < 100; n++) @(negedge clk);
        chk("reset_reached_writes", 32'(n_wacc >= 100), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_write", 32'(master_write), 32'd0);
        chk("rst_mid_read", 32'(master_read), 32'd0);
        @(negedge clk);
        chk("rst_mid_write2", 32'(master_write), 32'd0);
        #1 rst_n = 1'b1;
        clear_board();
        brd[0] = 5;
        brd[8] = 1;
        brd[2] = -1;
        run_case(0, 0, 8'h55, 7);

        // Random boards, origins, masks and ranges.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) brd[i] = ($urandom_range(0, 2) == 0) ? rnd_piece() : 0;
            rx = int'($urandom_range(0, 7));
            ry = int'($urandom_range(0, 7));
            brd[ry * 8 + rx] = (r == 5) ? 0 : rnd_piece();
            stall_en = 1'($urandom_range(0, 1));
            run_case(rx, ry, 8'($urandom), int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
